// File: rtl/wb_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Default widths, the queued-entry bundle and pointer sizing.
package wb_pkg;

   localparam int WB_DWIDTH = 32;
   localparam int WB_AWIDTH = 5;
   localparam int WB_DEPTH  = 4;

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   localparam int WB_PTR_W = ptr_w(WB_DEPTH);

   typedef struct packed {
      logic                 live;
      logic [WB_AWIDTH-1:0] wa;
      logic [WB_DWIDTH-1:0] wd;
   } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus bundle: ALU source, long-latency source, RF write port,
// plus the pending mask and queue occupancy seen by the hazard unit.
interface wb_arbiter_if #(
   parameter int DWIDTH = wb_pkg::WB_DWIDTH,
   parameter int AWIDTH = wb_pkg::WB_AWIDTH,
   parameter int DEPTH  = wb_pkg::WB_DEPTH
);
   localparam int CW = wb_pkg::ptr_w(DEPTH) + 1;
   localparam int NR = 1 << AWIDTH;

   logic              alu_we;
   logic [AWIDTH-1:0] alu_wa;
   logic [DWIDTH-1:0] alu_wd;
   logic              ext_valid;
   logic              ext_ready;
   logic [AWIDTH-1:0] ext_wa;
   logic [DWIDTH-1:0] ext_wd;
   logic              we;
   logic [AWIDTH-1:0] wa;
   logic [DWIDTH-1:0] wd;
   logic [NR-1:0]     pend_mask;
   logic [CW-1:0]     fifo_cnt;

   modport master (
      output alu_we, alu_wa, alu_wd,
      output ext_valid, ext_wa, ext_wd,
      input  ext_ready, we, wa, wd, pend_mask, fifo_cnt
   );

   modport slave (
      input  alu_we, alu_wa, alu_wd,
      input  ext_valid, ext_wa, ext_wd,
      output ext_ready, we, wa, wd, pend_mask, fifo_cnt
   );

endinterface

// File: rtl/wb_fifo.sv
// Queue of long-latency register writes with per-entry live bits.
// An ALU write to the same register clears live on older entries.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DWIDTH = WB_DWIDTH,
   parameter int AWIDTH = WB_AWIDTH,
   parameter int DEPTH  = WB_DEPTH,
   localparam int PW    = ptr_w(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic [AWIDTH-1:0]             push_wa,
   input  logic [DWIDTH-1:0]             push_wd,
   input  logic                          pop,
   input  logic                          kill,
   input  logic [AWIDTH-1:0]             kill_wa,
   output logic                          head_live,
   output logic [AWIDTH-1:0]             head_wa,
   output logic [DWIDTH-1:0]             head_wd,
   output logic [DEPTH-1:0]              live_vec,
   output logic [DEPTH-1:0][AWIDTH-1:0]  wa_vec,
   output logic [CW-1:0]                 cnt
);

   logic [PW-1:0]                rd_q;
   logic [PW-1:0]                wr_q;
   logic [CW-1:0]                cnt_q;
   logic [DEPTH-1:0]             live_q;
   logic [DEPTH-1:0][AWIDTH-1:0] wa_q;
   logic [DWIDTH-1:0]            wd_q [DEPTH];

   // Pointers, count and live bits; push overrides kill on its own slot.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_q   <= '0;
         wr_q   <= '0;
         cnt_q  <= '0;
         live_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (kill && (wa_q[i] == kill_wa)) begin
               live_q[i] <= 1'b0;
            end
         end
         if (pop) begin
            live_q[rd_q] <= 1'b0;
            rd_q         <= rd_q + PW'(1);
         end
         if (push) begin
            live_q[wr_q] <= (push_wa != '0);
            wr_q         <= wr_q + PW'(1);
         end
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Entry payload; no reset needed since live gates every use.
   always_ff @(posedge clk) begin
      if (push) begin
         wa_q[wr_q] <= push_wa;
         wd_q[wr_q] <= push_wd;
      end
   end

   assign head_live = (cnt_q != '0) && live_q[rd_q];
   assign head_wa   = wa_q[rd_q];
   assign head_wd   = wd_q[rd_q];
   assign live_vec  = live_q;
   assign wa_vec    = wa_q;
   assign cnt       = cnt_q;

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: ALU first, then queued long-latency
// writes. Optional same-cycle bypass of an empty queue: WB_BYPASS_EN.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int DWIDTH = WB_DWIDTH,
   parameter int AWIDTH = WB_AWIDTH,
   parameter int DEPTH  = WB_DEPTH,
   localparam int CW    = ptr_w(DEPTH) + 1,
   localparam int NR    = 1 << AWIDTH
) (
   input  logic         clk,
   input  logic         rst,
   wb_arbiter_if.slave  bus
);

   logic                         alu_hit;
   logic                         byp;
   logic                         push;
   logic                         pop;
   logic                         empty;
   logic                         head_live;
   logic [AWIDTH-1:0]            head_wa;
   logic [DWIDTH-1:0]            head_wd;
   logic [DEPTH-1:0]             live_vec;
   logic [DEPTH-1:0][AWIDTH-1:0] wa_vec;
   logic [CW-1:0]                cnt;
   logic [NR-1:0]                pend;

   assign alu_hit = bus.alu_we && (bus.alu_wa != '0);
   assign empty   = (cnt == '0);

`ifdef WB_BYPASS_EN
   assign byp = empty && !alu_hit && bus.ext_valid && (bus.ext_wa != '0);
`else
   assign byp = 1'b0;
`endif

   assign bus.ext_ready = (cnt != CW'(DEPTH));
   assign push          = bus.ext_valid && bus.ext_ready && !byp;
   assign pop           = !empty && !alu_hit;

   wb_fifo #(
      .DWIDTH (DWIDTH),
      .AWIDTH (AWIDTH),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_wa   (bus.ext_wa),
      .push_wd   (bus.ext_wd),
      .pop       (pop),
      .kill      (alu_hit),
      .kill_wa   (bus.alu_wa),
      .head_live (head_live),
      .head_wa   (head_wa),
      .head_wd   (head_wd),
      .live_vec  (live_vec),
      .wa_vec    (wa_vec),
      .cnt       (cnt)
   );

   // Write-port select; held idle while reset is asserted.
   always_comb begin
      bus.we = 1'b0;
      bus.wa = '0;
      bus.wd = '0;
      if (!rst) begin
         bus.we = 1'b0;
      end else if (alu_hit) begin
         bus.we = 1'b1;
         bus.wa = bus.alu_wa;
         bus.wd = bus.alu_wd;
      end else if (head_live) begin
         bus.we = 1'b1;
         bus.wa = head_wa;
         bus.wd = head_wd;
      end else if (byp) begin
         bus.we = 1'b1;
         bus.wa = bus.ext_wa;
         bus.wd = bus.ext_wd;
      end
   end

   // One-hot OR of every live queued destination.
   always_comb begin
      pend = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (live_vec[i]) begin
            pend[wa_vec[i]] = 1'b1;
         end
      end
   end

   assign bus.pend_mask = pend;
   assign bus.fifo_cnt  = cnt;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: scenario tasks plus a write-port scoreboard
// that checks every RF write against the expected order.
module tb_wb_arbiter;
   import wb_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   vec  = 0;
   int   errs = 0;

   wb_entry_t   exp_q [$];
   wb_entry_t   mon_e;
   logic [31:0] rf [32];

   always #5 clk = ~clk;

   wb_arbiter_if #(.DWIDTH(32), .AWIDTH(5), .DEPTH(4)) bus ();

   wb_arbiter #(
      .DWIDTH (32),
      .AWIDTH (5),
      .DEPTH  (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Every RF write must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst === 1'b1 && bus.we === 1'b1) begin
         vec++;
         rf[bus.wa] = bus.wd;
         if (exp_q.size() == 0) begin
            errs++;
            $display("FAIL rf_write got wa=%0d wd=%h want no write",
                     bus.wa, bus.wd);
         end else begin
            mon_e = exp_q.pop_front();
            if (bus.wa !== mon_e.wa || bus.wd !== mon_e.wd) begin
               errs++;
               $display("FAIL rf_write got wa=%0d wd=%h want wa=%0d wd=%h",
                        bus.wa, bus.wd, mon_e.wa, mon_e.wd);
            end
         end
      end
   end

   task automatic idle();
      bus.alu_we    = 1'b0;
      bus.alu_wa    = '0;
      bus.alu_wd    = '0;
      bus.ext_valid = 1'b0;
      bus.ext_wa    = '0;
      bus.ext_wd    = '0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
      wb_entry_t e;
      e.live = 1'b1;
      e.wa   = a;
      e.wd   = d;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      vec++;
      if (bus.ext_ready !== 1'b1 || bus.we !== 1'b0 || bus.wa !== 5'd0 ||
          bus.wd !== 32'd0) begin
         errs++;
         $display("FAIL reset_port got rdy=%b we=%b wa=%0d wd=%h want 1 0 0 0",
                  bus.ext_ready, bus.we, bus.wa, bus.wd);
      end
      vec++;
      if (bus.pend_mask !== 32'd0 || bus.fifo_cnt !== 3'd0) begin
         errs++;
         $display("FAIL reset_state got pend=%h cnt=%0d want 0 0",
                  bus.pend_mask, bus.fifo_cnt);
      end
      cyc();
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bus.alu_we    = 1'b1;
         bus.alu_wa    = 5'd9;
         bus.alu_wd    = 32'h900 + k;
         bus.ext_valid = 1'b1;
         bus.ext_wa    = 5'(k + 1);
         bus.ext_wd    = 32'h200 + k;
         expect_wr(5'd9, 32'h900 + k);
         cyc();
      end
      vec++;
      if (bus.fifo_cnt !== 3'd3) begin
         errs++;
         $display("FAIL pre_reset_cnt got %0d want 3", bus.fifo_cnt);
      end
      idle();
      rst = 1'b0;
      #1;
      vec++;
      if (bus.fifo_cnt !== 3'd0 || bus.pend_mask !== 32'd0 ||
          bus.we !== 1'b0) begin
         errs++;
         $display("FAIL async_reset got cnt=%0d pend=%h we=%b want 0 0 0",
                  bus.fifo_cnt, bus.pend_mask, bus.we);
      end
      cyc();
      rst = 1'b1;
      @(negedge clk);
      vec++;
      if (bus.ext_ready !== 1'b1 || bus.fifo_cnt !== 3'd0) begin
         errs++;
         $display("FAIL post_reset got rdy=%b cnt=%0d want 1 0",
                  bus.ext_ready, bus.fifo_cnt);
      end
   endtask

   task automatic test_single();
      cyc();
      idle();
      bus.ext_valid = 1'b1;
      bus.ext_wa    = 5'd5;
      bus.ext_wd    = 32'hDEADBEEF;
      expect_wr(5'd5, 32'hDEADBEEF);
      @(negedge clk);
      vec++;
      if (bus.we !== 1'b0 || bus.fifo_cnt !== 3'd0) begin
         errs++;
         $display("FAIL single_accept got we=%b cnt=%0d want 0 0",
                  bus.we, bus.fifo_cnt);
      end
      cyc();
      idle();
      @(negedge clk);
      vec++;
      if (bus.we !== 1'b1 || bus.wa !== 5'd5 || bus.pend_mask !== 32'h20 ||
          bus.fifo_cnt !== 3'd1) begin
         errs++;
         $display("FAIL single_drain got we=%b wa=%0d pend=%h cnt=%0d want 1 5 20 1",
                  bus.we, bus.wa, bus.pend_mask, bus.fifo_cnt);
      end
      cyc();
      @(negedge clk);
      vec++;
      if (bus.we !== 1'b0 || bus.pend_mask !== 32'd0 ||
          bus.fifo_cnt !== 3'd0) begin
         errs++;
         $display("FAIL single_done got we=%b pend=%h cnt=%0d want 0 0 0",
                  bus.we, bus.pend_mask, bus.fifo_cnt);
      end
   endtask

   task automatic test_fill();
      for (int k = 1; k <= 4; k++) begin
         cyc();
         bus.alu_we    = 1'b1;
         bus.alu_wa    = 5'd9;
         bus.alu_wd    = 32'h9A0 + k;
         bus.ext_valid = 1'b1;
         bus.ext_wa    = 5'(k);
         bus.ext_wd    = 32'h100 + k;
         expect_wr(5'd9, 32'h9A0 + k);
         @(negedge clk);
         vec++;
         if (bus.ext_ready !== 1'b1) begin
            errs++;
            $display("FAIL fill_ready[%0d] got %b want 1", k, bus.ext_ready);
         end
      end
      cyc();
      bus.alu_wd = 32'h9AF;
      bus.ext_wa = 5'd6;
      bus.ext_wd = 32'h666;
      expect_wr(5'd9, 32'h9AF);
      for (int k = 1; k <= 4; k++) expect_wr(5'(k), 32'h100 + k);
      @(negedge clk);
      vec++;
      if (bus.ext_ready !== 1'b0 || bus.fifo_cnt !== 3'd4 ||
          bus.pend_mask !== 32'h1E) begin
         errs++;
         $display("FAIL fill_full got rdy=%b cnt=%0d pend=%h want 0 4 1e",
                  bus.ext_ready, bus.fifo_cnt, bus.pend_mask);
      end
      cyc();
      idle();
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         vec++;
         if (bus.we !== 1'b1 || bus.wa !== 5'(k)) begin
            errs++;
            $display("FAIL drain_order[%0d] got we=%b wa=%0d want 1 %0d",
                     k, bus.we, bus.wa, k);
         end
         cyc();
      end
      @(negedge clk);
      vec++;
      if (bus.fifo_cnt !== 3'd0 || bus.we !== 1'b0) begin
         errs++;
         $display("FAIL drain_done got cnt=%0d we=%b want 0 0",
                  bus.fifo_cnt, bus.we);
      end
   endtask

   task automatic test_kill();
      cyc();
      idle();
      bus.ext_valid = 1'b1;
      bus.ext_wa    = 5'd7;
      bus.ext_wd    = 32'h11;
      cyc();
      idle();
      bus.alu_we = 1'b1;
      bus.alu_wa = 5'd7;
      bus.alu_wd = 32'h22;
      expect_wr(5'd7, 32'h22);
      @(negedge clk);
      vec++;
      if (bus.we !== 1'b1 || bus.wd !== 32'h22) begin
         errs++;
         $display("FAIL kill_alu got we=%b wd=%h want 1 22", bus.we, bus.wd);
      end
      cyc();
      idle();
      @(negedge clk);
      vec++;
      if (bus.pend_mask !== 32'd0 || bus.fifo_cnt !== 3'd1 ||
          bus.we !== 1'b0) begin
         errs++;
         $display("FAIL kill_dead got pend=%h cnt=%0d we=%b want 0 1 0",
                  bus.pend_mask, bus.fifo_cnt, bus.we);
      end
      cyc();
      @(negedge clk);
      vec++;
      if (bus.fifo_cnt !== 3'd0 || rf[7] !== 32'h22) begin
         errs++;
         $display("FAIL kill_result got cnt=%0d rf7=%h want 0 22",
                  bus.fifo_cnt, rf[7]);
      end
   endtask

   task automatic test_zero();
      cyc();
      idle();
      bus.ext_valid = 1'b1;
      bus.ext_wa    = 5'd0;
      bus.ext_wd    = 32'h77;
      bus.alu_we    = 1'b1;
      bus.alu_wa    = 5'd0;
      bus.alu_wd    = 32'h88;
      @(negedge clk);
      vec++;
      if (bus.we !== 1'b0) begin
         errs++;
         $display("FAIL zero_alu got we=%b want 0", bus.we);
      end
      cyc();
      idle();
      @(negedge clk);
      vec++;
      if (bus.fifo_cnt !== 3'd1 || bus.we !== 1'b0 ||
          bus.pend_mask !== 32'd0) begin
         errs++;
         $display("FAIL zero_queued got cnt=%0d we=%b pend=%h want 1 0 0",
                  bus.fifo_cnt, bus.we, bus.pend_mask);
      end
      cyc();
      @(negedge clk);
      vec++;
      if (bus.fifo_cnt !== 3'd0 || bus.we !== 1'b0) begin
         errs++;
         $display("FAIL zero_drained got cnt=%0d we=%b want 0 0",
                  bus.fifo_cnt, bus.we);
      end
   endtask

   task automatic test_bypass();
      cyc();
      idle();
      bus.ext_valid = 1'b1;
      bus.ext_wa    = 5'd3;
      bus.ext_wd    = 32'h55;
      expect_wr(5'd3, 32'h55);
      @(negedge clk);
`ifdef WB_BYPASS_EN
      vec++;
      if (bus.we !== 1'b1 || bus.wa !== 5'd3 || bus.ext_ready !== 1'b1) begin
         errs++;
         $display("FAIL bypass_same got we=%b wa=%0d rdy=%b want 1 3 1",
                  bus.we, bus.wa, bus.ext_ready);
      end
      cyc();
      idle();
      @(negedge clk);
      vec++;
      if (bus.fifo_cnt !== 3'd0 || bus.we !== 1'b0) begin
         errs++;
         $display("FAIL bypass_nopush got cnt=%0d we=%b want 0 0",
                  bus.fifo_cnt, bus.we);
      end
`else
      vec++;
      if (bus.we !== 1'b0 || bus.fifo_cnt !== 3'd0) begin
         errs++;
         $display("FAIL nobypass_same got we=%b cnt=%0d want 0 0",
                  bus.we, bus.fifo_cnt);
      end
      cyc();
      idle();
      @(negedge clk);
      vec++;
      if (bus.we !== 1'b1 || bus.wa !== 5'd3 || bus.fifo_cnt !== 3'd1) begin
         errs++;
         $display("FAIL nobypass_next got we=%b wa=%0d cnt=%0d want 1 3 1",
                  bus.we, bus.wa, bus.fifo_cnt);
      end
      cyc();
      @(negedge clk);
      vec++;
      if (bus.fifo_cnt !== 3'd0) begin
         errs++;
         $display("FAIL nobypass_done got cnt=%0d want 0", bus.fifo_cnt);
      end
`endif
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = '0;
      test_reset();
      test_single();
      test_fill();
      test_kill();
      test_zero();
      test_bypass();
      repeat (2) cyc();
      vec++;
      if (exp_q.size() != 0) begin
         errs++;
         $display("FAIL missing_writes got %0d outstanding want 0",
                  exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
